scm_map: RTL and testbench



---
 rtl/scm_map_if.sv | 32 +++
 rtl/scm_map.sv | 204 ++++++++++++++++++++
 tb/tb_scm_map.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/scm_map_if.sv
// scm_map_if: bundles the serial bit handshake and the mapped I/Q sample
// stream of scm_map. The master side feeds bits and watches the samples;
// the slave side is the mapper itself.
interface scm_map_if;
   logic               di;
   logic               di_vld;
   logic               di_rdy;
   logic signed [11:0] do_re;
   logic signed [11:0] do_im;
   logic               do_vld;
   logic               busy;

   modport master (
      output di,
      output di_vld,
      input  di_rdy,
      input  do_re,
      input  do_im,
      input  do_vld,
      input  busy
   );

   modport slave (
      input  di,
      input  di_vld,
      output di_rdy,
      output do_re,
      output do_im,
      output do_vld,
      output busy
   );
endinterface

// File: rtl/scm_map.sv
// scm_map: signal constellation mapper for the transmit signal segment.
// Collects FRAME_BITS = 960/REP serial bits, then emits one gap-free
// 512-sample frame: 16 zero guard samples, 480 QPSK samples built from the
// REP-times repeated bit stream (bit 0 -> +AMP, bit 1 -> -AMP), 16 zero
// guard samples.
// Optional build macro SCM_SCRAMBLE_EN: XORs each coded bit with a 7-bit
// LFSR (x^7+x^4+1, seed 7'h7F at frame start) before mapping.
module scm_map #(
   parameter int REP = 4,
   parameter int AMP = 724
) (
   input logic      clk,
   input logic      rst_n,
   scm_map_if.slave bus
);

   localparam int DATA_W     = 12;
   localparam int FRAME_BITS = 960 / REP;
   localparam int CNT_W      = $clog2(FRAME_BITS);
   localparam int REP_SH     = $clog2(REP);

   localparam logic [8:0]        LAST_IDX   = 9'd511;
   localparam logic [8:0]        FIRST_DATA = 9'd16;
   localparam logic [8:0]        FIRST_POST = 9'd496;
   localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(FRAME_BITS - 1);
   localparam logic signed [DATA_W-1:0] AMP_S = DATA_W'(AMP);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      PRE  = 2'd1,
      DATA = 2'd2,
      POST = 2'd3
   } state_t;

   // Coded bit 0 maps to +AMP, coded bit 1 to the two's complement -AMP.
   function automatic logic signed [DATA_W-1:0] map_bit(input logic b);
      return b ? -AMP_S : AMP_S;
   endfunction

   // Frame region that a given sample index falls into.
   function automatic state_t region(input logic [8:0] i);
      if (i < FIRST_DATA) begin
         return PRE;
      end else if (i < FIRST_POST) begin
         return DATA;
      end else begin
         return POST;
      end
   endfunction

   // Buffer position of coded bit k: each stored bit is repeated REP times.
   function automatic logic [CNT_W-1:0] buf_pos(input logic [9:0] k);
      return CNT_W'(k >> REP_SH);
   endfunction

   state_t                   state;
   state_t                   state_nxt;
   logic [8:0]               idx;
   logic [8:0]               idx_nxt;
   logic [CNT_W-1:0]         bit_cnt;
   logic [CNT_W-1:0]         bit_cnt_nxt;
   logic [FRAME_BITS-1:0]    frame_q;
   logic                     take;
   logic                     rdy_q;
   logic                     vld_q;
   logic signed [DATA_W-1:0] re_q;
   logic signed [DATA_W-1:0] im_q;
   logic signed [DATA_W-1:0] re_nxt;
   logic signed [DATA_W-1:0] im_nxt;
   logic [8:0]               sym_nxt;
   logic [9:0]               k_i;
   logic [9:0]               k_q;
   logic                     b_i;
   logic                     b_q;
   logic                     map_i;
   logic                     map_q;

   assign take = bus.di_vld & rdy_q;

   // State, sample index and bit counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= LOAD;
         idx     <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   // Next state: fill the buffer in LOAD, then walk the 512 sample indices.
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      bit_cnt_nxt = bit_cnt;
      case (state)
         LOAD: begin
            if (take) begin
               if (bit_cnt == LAST_BIT) begin
                  state_nxt   = PRE;
                  idx_nxt     = '0;
                  bit_cnt_nxt = '0;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         end
         default: begin
            if (idx == LAST_IDX) begin
               state_nxt = LOAD;
               idx_nxt   = '0;
            end else begin
               idx_nxt   = idx + 1'b1;
               state_nxt = region(idx + 1'b1);
            end
         end
      endcase
   end

   // Frame buffer: one stored bit per accepted handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q <= '0;
      end else if (take) begin
         frame_q[bit_cnt] <= bus.di;
      end
   end

   // Coded bits for the sample that is about to be registered: I takes
   // c[2j], Q takes c[2j+1].
   assign sym_nxt = idx_nxt - FIRST_DATA;
   assign k_i     = {sym_nxt, 1'b0};
   assign k_q     = {sym_nxt, 1'b1};
   assign b_i     = frame_q[buf_pos(k_i)];
   assign b_q     = frame_q[buf_pos(k_q)];

`ifdef SCM_SCRAMBLE_EN
   logic [6:0] lfsr;
   logic [6:0] lfsr_mid;
   logic [6:0] lfsr_nxt;
   logic       s_i;
   logic       s_q;

   // Two LFSR steps per sample, the first one scrambling I, the second Q.
   always_comb begin
      s_i      = lfsr[6] ^ lfsr[3];
      lfsr_mid = {lfsr[5:0], s_i};
      s_q      = lfsr_mid[6] ^ lfsr_mid[3];
      lfsr_nxt = {lfsr_mid[5:0], s_q};
   end

   // Reseed at frame start, advance only while DATA samples are produced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= 7'h7F;
      end else if (state == LOAD && state_nxt == PRE) begin
         lfsr <= 7'h7F;
      end else if (state_nxt == DATA) begin
         lfsr <= lfsr_nxt;
      end
   end

   assign map_i = b_i ^ s_i;
   assign map_q = b_q ^ s_q;
`else
   assign map_i = b_i;
   assign map_q = b_q;
`endif

   // Guard samples are zero; only DATA samples carry mapped values.
   always_comb begin
      re_nxt = '0;
      im_nxt = '0;
      if (state_nxt == DATA) begin
         re_nxt = map_bit(map_i);
         im_nxt = map_bit(map_q);
      end
   end

   // Output registers follow the next state so sample 0 appears right
   // after the final bit handshake and di_rdy drops on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b0;
         vld_q <= 1'b0;
         re_q  <= '0;
         im_q  <= '0;
      end else begin
         rdy_q <= (state_nxt == LOAD);
         vld_q <= (state_nxt != LOAD);
         re_q  <= re_nxt;
         im_q  <= im_nxt;
      end
   end

   assign bus.di_rdy = rdy_q;
   assign bus.do_vld = vld_q;
   assign bus.do_re  = re_q;
   assign bus.do_im  = im_q;
   assign bus.busy   = (state != LOAD);

endmodule

// File: tb/tb_scm_map.sv
// tb_scm_map: randomized self-checking bench for scm_map. Three mappers
// (REP 4, 1, 2) share clock and reset; frames are driven with random
// di_vld gaps and every emitted sample is compared with a model computed
// directly from the frame rules.
module tb_scm_map;

   localparam int NDUT = 3;
   localparam int REP_T [NDUT] = '{4, 1, 2};
   localparam int AMP_T [NDUT] = '{724, 724, 2047};

   logic               clk = 1'b0;
   logic               rst_n;
   logic               di_a     [NDUT];
   logic               di_vld_a [NDUT];
   logic               rdy_a    [NDUT];
   logic               vld_a    [NDUT];
   logic               busy_a   [NDUT];
   logic signed [11:0] re_a     [NDUT];
   logic signed [11:0] im_a     [NDUT];
   bit                 fbits    [960];
   int                 n_chk  = 0;
   int                 n_pass = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      scm_map_if ifc ();
      scm_map #(
         .REP (REP_T[g]),
         .AMP (AMP_T[g])
      ) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (ifc.slave)
      );
      assign ifc.di      = di_a[g];
      assign ifc.di_vld  = di_vld_a[g];
      assign rdy_a[g]    = ifc.di_rdy;
      assign vld_a[g]    = ifc.do_vld;
      assign busy_a[g]   = ifc.busy;
      assign re_a[g]     = ifc.do_re;
      assign im_a[g]     = ifc.do_im;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input int g, input string tag, input int rdy);
      check($sformatf("g%0d %s rdy", g, tag), int'(rdy_a[g]), rdy);
      check($sformatf("g%0d %s vld", g, tag), int'(vld_a[g]), 0);
      check($sformatf("g%0d %s busy", g, tag), int'(busy_a[g]), 0);
      check($sformatf("g%0d %s re", g, tag), int'(re_a[g]), 0);
      check($sformatf("g%0d %s im", g, tag), int'(im_a[g]), 0);
   endtask

   // Drive fbits into DUT g and check the 512-sample frame; with
   // stop_at >= 0 return right after checking that sample index.
   task automatic run_frame(input int g, input int stop_at);
      int       rep;
      int       amp;
      int       nb;
      int       guard;
      int       er;
      int       ei;
      int       j;
      bit       cb [960];
      logic [6:0] lf;
      bit       s;
      rep = REP_T[g];
      amp = AMP_T[g];
      nb  = 960 / rep;
      for (int k = 0; k < 960; k++) cb[k] = fbits[k / rep];
`ifdef SCM_SCRAMBLE_EN
      lf = 7'h7F;
      for (int k = 0; k < 960; k++) begin
         s     = lf[6] ^ lf[3];
         lf    = {lf[5:0], s};
         cb[k] = cb[k] ^ s;
      end
`else
      lf = 7'h00;
      s  = 1'b0;
`endif
      for (int i = 0; i < nb; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            di_vld_a[g] = 1'b0;
            di_a[g]     = 1'($urandom_range(0, 1));
            @(posedge clk);
         end
         @(negedge clk);
         di_a[g]     = fbits[i];
         di_vld_a[g] = 1'b1;
         if (i == nb - 1) begin
            check($sformatf("g%0d vld before last bit", g), int'(vld_a[g]), 0);
            check($sformatf("g%0d busy before last bit", g), int'(busy_a[g]), 0);
         end
         guard = 0;
         while (!rdy_a[g] && guard < 50) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
         end
         if (!rdy_a[g]) begin
            check($sformatf("g%0d di_rdy timeout bit %0d", g, i), 0, 1);
            di_vld_a[g] = 1'b0;
            return;
         end
         @(posedge clk);
      end
      for (int n = 0; n < 512; n++) begin
         @(negedge clk);
         if (n == 0) begin
            di_vld_a[g] = 1'b1;
            di_a[g]     = 1'b1;
         end
         if (n < 16 || n >= 496) begin
            er = 0;
            ei = 0;
         end else begin
            j  = n - 16;
            er = cb[2 * j] ? -amp : amp;
            ei = cb[2 * j + 1] ? -amp : amp;
         end
         check($sformatf("g%0d vld[%0d]", g, n), int'(vld_a[g]), 1);
         check($sformatf("g%0d re[%0d]", g, n), int'(re_a[g]), er);
         check($sformatf("g%0d im[%0d]", g, n), int'(im_a[g]), ei);
         if (n == 0 || n == 511) begin
            check($sformatf("g%0d rdy[%0d]", g, n), int'(rdy_a[g]), 0);
            check($sformatf("g%0d busy[%0d]", g, n), int'(busy_a[g]), 1);
         end
         if (n == stop_at) return;
      end
      @(negedge clk);
      di_vld_a[g] = 1'b0;
      check_idle(g, "after frame", 1);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 960; i++) fbits[i] = 1'($urandom_range(0, 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      for (int g = 0; g < NDUT; g++) begin
         di_a[g]     = 1'b0;
         di_vld_a[g] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < NDUT; g++) check_idle(g, "in reset", 0);
      rst_n = 1'b1;
      #1;
      check("g0 rdy before first edge", int'(rdy_a[0]), 0);
      @(posedge clk);
      #1;
      for (int g = 0; g < NDUT; g++) check_idle(g, "first edge", 1);

      for (int i = 0; i < 960; i++) fbits[i] = 1'b0;
      run_frame(0, -1);
      fill_random();
      run_frame(0, -1);

      for (int i = 0; i < 960; i++) fbits[i] = (i % 2 == 0);
      run_frame(1, -1);
      run_frame(2, -1);
      fill_random();
      run_frame(1, -1);
      fill_random();
      run_frame(2, -1);

      fill_random();
      run_frame(0, 116);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle(0, "async reset", 0);
      @(negedge clk);
      rst_n       = 1'b1;
      di_vld_a[0] = 1'b0;
      @(posedge clk);
      #1;
      check("g0 rdy after reset release", int'(rdy_a[0]), 1);
      repeat (20) begin
         @(negedge clk);
         check("g0 vld idle after reset", int'(vld_a[0]), 0);
      end
      fill_random();
      run_frame(0, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
